// File: rtl/reg_seq_pkg.sv
// Shared encodings for the register command sequencer.
// Op codes, FSM states and the repeat-op helper.
package reg_seq_pkg;

    localparam logic [2:0] OP_CLR  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_INC  = 3'd2;
    localparam logic [2:0] OP_DEC  = 3'd3;
    localparam logic [2:0] OP_SHR  = 3'd4;
    localparam logic [2:0] OP_SHL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;
    localparam logic [2:0] OP_ROL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_repeat(input logic [2:0] op);
        return (op != OP_CLR) && (op != OP_LOAD);
    endfunction

endpackage

// File: rtl/reg_seq_ctrl_register.sv
// General-purpose register with clear/load/inc/dec/shift controls.
// Controls are prioritised cl > ld > inc > dec > sr > sl.
module register #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cl,
    input  logic                  ld,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  sr,
    input  logic                  ir,
    input  logic                  sl,
    input  logic                  il,
    input  logic [DATA_WIDTH-1:0] in,
    output logic [DATA_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (cl) begin
            q <= '0;
        end else if (ld) begin
            q <= in;
        end else if (inc) begin
            q <= q + DATA_WIDTH'(1);
        end else if (dec) begin
            q <= q - DATA_WIDTH'(1);
        end else if (sr) begin
            q <= {ir, q[DATA_WIDTH-1:1]};
        end else if (sl) begin
            q <= {q[DATA_WIDTH-2:0], il};
        end
    end

endmodule

// File: rtl/reg_seq_ctrl.sv
// Multi-cycle command sequencer driving one register's control pins.
// Accepts a command, repeats the op N times, then pulses done.
module reg_seq_ctrl
    import reg_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [CNT_WIDTH-1:0]  cmd_amt,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [DATA_WIDTH-1:0] reg_q,
    output logic                  reg_cl,
    output logic                  reg_ld,
    output logic                  reg_inc,
    output logic                  reg_dec,
    output logic                  reg_sr,
    output logic                  reg_ir,
    output logic                  reg_sl,
    output logic                  reg_il,
    output logic [DATA_WIDTH-1:0] reg_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);

    state_t                  state_q;
    state_t                  state_d;
    logic [2:0]              op_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CNT_WIDTH-1:0]    n_eff;
    logic [CNT_WIDTH-1:0]    cnt_q;
    logic                    accept;
    logic                    in_exec;

    assign accept  = cmd_valid && cmd_ready;
    assign in_exec = (state_q == ST_EXEC);
    assign n_eff   = op_is_repeat(cmd_op) ? cmd_amt : CNT_WIDTH'(1);

    // Remaining-count counter: loaded with N at accept, counts down in EXEC.
    register #(
        .DATA_WIDTH(CNT_WIDTH)
    ) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .cl   (1'b0),
        .ld   (accept),
        .inc  (1'b0),
        .dec  (in_exec),
        .sr   (1'b0),
        .ir   (1'b0),
        .sl   (1'b0),
        .il   (1'b0),
        .in   (n_eff),
        .q    (cnt_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLR;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (n_eff == '0) ? ST_DONE : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore controls; serial-in bits follow the live register edge bits.
    always_comb begin
        reg_cl  = 1'b0;
        reg_ld  = 1'b0;
        reg_inc = 1'b0;
        reg_dec = 1'b0;
        reg_sr  = 1'b0;
        reg_ir  = 1'b0;
        reg_sl  = 1'b0;
        reg_il  = 1'b0;
        if (in_exec) begin
            unique case (op_q)
                OP_CLR:  reg_cl  = 1'b1;
                OP_LOAD: reg_ld  = 1'b1;
                OP_INC:  reg_inc = 1'b1;
                OP_DEC:  reg_dec = 1'b1;
                OP_SHR:  reg_sr  = 1'b1;
                OP_SHL:  reg_sl  = 1'b1;
                OP_ROR: begin
                    reg_sr = 1'b1;
                    reg_ir = reg_q[0];
                end
                OP_ROL: begin
                    reg_sl = 1'b1;
                    reg_il = reg_q[DATA_WIDTH-1];
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_EXEC) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign reg_in    = data_q;
    assign result    = reg_q;

endmodule

// File: tb/tb_reg_seq_ctrl.sv
// Bench for reg_seq_ctrl: directed plan plus random commands,
// with a behavioural register and an arithmetic result model.
module tb_reg_seq_ctrl;
    import reg_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_amt;
    logic [15:0] cmd_data;
    logic [15:0] dp_q;
    logic        reg_cl, reg_ld, reg_inc, reg_dec;
    logic        reg_sr, reg_ir, reg_sl, reg_il;
    logic [15:0] reg_in;
    logic        busy, done;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_seq_ctrl #(
        .DATA_WIDTH(16),
        .CNT_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_amt  (cmd_amt),
        .cmd_data (cmd_data),
        .reg_q    (dp_q),
        .reg_cl   (reg_cl),
        .reg_ld   (reg_ld),
        .reg_inc  (reg_inc),
        .reg_dec  (reg_dec),
        .reg_sr   (reg_sr),
        .reg_ir   (reg_ir),
        .reg_sl   (reg_sl),
        .reg_il   (reg_il),
        .reg_in   (reg_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    // Behavioural datapath register owned by the sequencer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       dp_q <= 16'h0;
        else if (reg_cl)  dp_q <= 16'h0;
        else if (reg_ld)  dp_q <= reg_in;
        else if (reg_inc) dp_q <= dp_q + 16'h1;
        else if (reg_dec) dp_q <= dp_q - 16'h1;
        else if (reg_sr)  dp_q <= {reg_ir, dp_q[15:1]};
        else if (reg_sl)  dp_q <= {dp_q[14:0], reg_il};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] op,
                                          input logic [3:0] amt,
                                          input logic [15:0] d,
                                          input logic [15:0] q);
        logic [31:0] qq;
        int n;
        n  = int'(amt);
        qq = {q, q};
        case (op)
            OP_CLR:  return 16'h0;
            OP_LOAD: return d;
            OP_INC:  return q + 16'(amt);
            OP_DEC:  return q - 16'(amt);
            OP_SHR:  return q >> n;
            OP_SHL:  return q << n;
            OP_ROR: begin
                qq = qq >> n;
                return qq[15:0];
            end
            default: begin
                qq = qq << n;
                return qq[31:16];
            end
        endcase
    endfunction

    function automatic logic [5:0] pin_of(input logic [2:0] op);
        case (op)
            OP_CLR:  return 6'b100000;
            OP_LOAD: return 6'b010000;
            OP_INC:  return 6'b001000;
            OP_DEC:  return 6'b000100;
            OP_SHR, OP_ROR: return 6'b000010;
            default: return 6'b000001;
        endcase
    endfunction

    // Starts at a falling edge in an idle cycle; returns at the falling
    // edge of the first idle cycle after done.
    task automatic run_cmd(input logic [2:0] op, input logic [3:0] amt,
                           input logic [15:0] d, input bit keep,
                           input logic [2:0] nop, input logic [3:0] namt,
                           input logic [15:0] nd, output logic [15:0] res);
        logic [15:0] expv;
        int n;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = d;
        chk("ready_at_issue", 32'(cmd_ready), 32'd1);
        expv = model(op, amt, d, dp_q);
        n = (op == OP_CLR || op == OP_LOAD) ? 1 : int'(amt);
        @(posedge clk);
        #1;
        if (keep) begin
            cmd_op   = nop;
            cmd_amt  = namt;
            cmd_data = nd;
        end else begin
            cmd_valid = 1'b0;
            cmd_op    = 3'($urandom);
            cmd_amt   = 4'($urandom);
            cmd_data  = 16'($urandom);
        end
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("exec_pins",
                32'({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl}),
                32'(pin_of(op)));
            chk("exec_ir", 32'(reg_ir),
                32'((op == OP_ROR) ? dp_q[0] : 1'b0));
            chk("exec_il", 32'(reg_il),
                32'((op == OP_ROL) ? dp_q[15] : 1'b0));
            chk("exec_stat", 32'({busy, done, cmd_ready}), 32'(3'b100));
        end
        @(negedge clk);
        chk("done_stat", 32'({busy, done, cmd_ready}), 32'(3'b110));
        chk("done_pins",
            32'({reg_cl, reg_ld, reg_inc, reg_dec,
                 reg_sr, reg_sl, reg_ir, reg_il}), 32'd0);
        chk("done_result", 32'(result), 32'(expv));
        chk("done_reg_in", 32'(reg_in), 32'(d));
        res = result;
        @(negedge clk);
        chk("idle_stat", 32'({busy, done, cmd_ready}), 32'(3'b001));
    endtask

    initial begin
        logic [15:0] r;
        logic [2:0]  c_op, n_op;
        logic [3:0]  c_amt, n_amt;
        logic [15:0] c_d, n_d;
        bit          kp;

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_amt   = 4'd0;
        cmd_data  = 16'h0;
        #3;
        chk("rst_stat", 32'({busy, done, cmd_ready}), 32'(3'b001));
        chk("rst_pins",
            32'({reg_cl, reg_ld, reg_inc, reg_dec,
                 reg_sr, reg_sl, reg_ir, reg_il}), 32'd0);
        chk("rst_reg_in", 32'(reg_in), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_cmd(OP_LOAD, 4'd0, 16'h00F0, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p1_load", 32'(r), 32'h00F0);

        run_cmd(OP_LOAD, 4'd0, 16'h8001, 0, 3'd0, 4'd0, 16'h0, r);
        run_cmd(OP_ROL, 4'd4, 16'h0000, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p2_rol4", 32'(r), 32'h0018);

        run_cmd(OP_LOAD, 4'd0, 16'hFFFA, 0, 3'd0, 4'd0, 16'h0, r);
        run_cmd(OP_INC, 4'd15, 16'h0000, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p3_inc_wrap", 32'(r), 32'h0009);
        run_cmd(OP_DEC, 4'd9, 16'h0000, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p3_dec", 32'(r), 32'h0000);

        run_cmd(OP_LOAD, 4'd0, 16'h1234, 0, 3'd0, 4'd0, 16'h0, r);
        run_cmd(OP_SHL, 4'd0, 16'h0000, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p4_shl0", 32'(r), 32'h1234);
        run_cmd(OP_LOAD, 4'd0, 16'h0001, 0, 3'd0, 4'd0, 16'h0, r);
        run_cmd(OP_ROR, 4'd1, 16'h0000, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p4_ror1", 32'(r), 32'h8000);

        run_cmd(OP_LOAD, 4'd0, 16'hF000, 0, 3'd0, 4'd0, 16'h0, r);
        run_cmd(OP_SHR, 4'd3, 16'h0000, 1, OP_INC, 4'd2, 16'hABCD, r);
        chk("p5_shr3", 32'(r), 32'h1E00);
        run_cmd(OP_INC, 4'd2, 16'hABCD, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p5_inc2", 32'(r), 32'h1E02);

        cmd_valid = 1'b1;
        cmd_op    = OP_INC;
        cmd_amt   = 4'd8;
        cmd_data  = 16'h0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("p6_inc_live", 32'(reg_inc), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("p6_rst_pins",
            32'({reg_cl, reg_ld, reg_inc, reg_dec,
                 reg_sr, reg_sl, reg_ir, reg_il}), 32'd0);
        chk("p6_rst_stat", 32'({busy, done, cmd_ready}), 32'(3'b001));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("p6_no_done", 32'({busy, done}), 32'd0);
        end
        chk("p6_dp_q", 32'(dp_q), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_cmd(OP_CLR, 4'd5, 16'h5A5A, 0, 3'd0, 4'd0, 16'h0, r);
        chk("p6_clr", 32'(r), 32'h0000);

        n_op  = 3'($urandom);
        n_amt = 4'($urandom);
        n_d   = 16'($urandom);
        for (int i = 0; i < 60; i++) begin
            c_op  = n_op;
            c_amt = n_amt;
            c_d   = n_d;
            n_op  = 3'($urandom);
            n_amt = 4'($urandom);
            n_d   = 16'($urandom);
            kp    = 1'($urandom_range(0, 1));
            run_cmd(c_op, c_amt, c_d, kp, n_op, n_amt, n_d, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_seq_ctrl.md
Name: reg_seq_ctrl

Overview:
Multi-cycle command sequencer for a single `register` datapath instance. It accepts one command at a time over a valid/ready handshake. It then drives the register's cl/ld/inc/dec/sr/ir/sl/il/in pins for the required number of cycles, for example to rotate by N, shift by N, or add/subtract a small constant. It pulses done when the register holds the final value. It sits between the top-level control FSM and the general-purpose register it owns.

Parameters:
DATA_WIDTH, 16, width of the controlled register
CNT_WIDTH, 4, width of the repeat count; maximum repeat is 2^CNT_WIDTH-1

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE; command accepted on clk edge when cmd_valid&cmd_ready
cmd_op  in  3  0 CLR, 1 LOAD, 2 INC, 3 DEC, 4 SHR, 5 SHL, 6 ROR, 7 ROL
cmd_amt  in  CNT_WIDTH  repeat count for ops 2-7; ignored for CLR/LOAD
cmd_data  in  DATA_WIDTH  load value for LOAD
reg_q  in  DATA_WIDTH  current register output
reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_ir, reg_sl, reg_il  out  1 each  register control pins
reg_in  out  DATA_WIDTH  register load data
busy  out  1  high in EXEC and DONE
done  out  1  one-cycle completion pulse
result  out  DATA_WIDTH  equals reg_q; valid when done=1

Behaviour:
- States: IDLE, EXEC, DONE (binary encoded).
- IDLE → EXEC on accept when the effective count N ≥ 1.
  - N = 1 for CLR and LOAD; N = cmd_amt otherwise.
- IDLE → DONE on accept when N = 0. No control pin asserts; the register is untouched.
- Op, N and data are latched at accept. Later changes on cmd_* have no effect.
- EXEC lasts exactly N cycles; EXEC → DONE after the Nth cycle.
- DONE lasts one cycle, with done = 1; DONE → IDLE unconditionally.
- Latency: accept at edge T; EXEC occupies cycles T+1..T+N; done is high in cycle T+N+1. The next accept is possible at the end of cycle T+N+2.
- Control outputs are Moore, asserted only in EXEC. Exactly one of cl/ld/inc/dec/sr/sl is high; all are 0 in IDLE and DONE.
- reg_ir and reg_il:
  - ROR: reg_ir = reg_q[0]; SHR: reg_ir = 0.
  - ROL: reg_il = reg_q[DATA_WIDTH-1]; SHL: reg_il = 0.
  - Both are 0 for every other op.
- reg_in = latched cmd_data at all times; reg_in = 0 after reset.
- Arithmetic wraps modulo 2^DATA_WIDTH, inherited from the register (INC past all-ones wraps to 0).
- cmd_valid asserted while busy is ignored and not consumed. The requester must hold it until cmd_ready.
- Reset values: state IDLE; all reg_* controls 0; reg_in 0; done 0; busy 0. cmd_ready is 1 during and after reset.
- Reset mid-operation: immediate return to IDLE, all controls drop asynchronously, no done pulse. Register contents are whatever the register's own reset gives (0).
- Remaining-count counter:
  - loaded with N at accept, decremented each EXEC cycle;
  - EXEC exits when the counter equals 1 during EXEC;
  - the counter never underflows.

Decomposition:
- Package reg_seq_pkg holds:
  - op encodings OP_CLR..OP_ROL (3-bit localparams);
  - state encodings ST_IDLE, ST_EXEC, ST_DONE;
  - function op_is_repeat(op), true for ops 2-7.
- One sub-module: the remaining-count counter is an instance of `register` with DATA_WIDTH = CNT_WIDTH. Its ld is driven at accept and its dec in EXEC; cl, inc, sr and sl are tied 0.

Test Plan:
1. LOAD cmd_data=0x00F0 from reset → reg_ld high exactly 1 cycle with reg_in=0x00F0; done at T+2; result=0x00F0.
2. ROL amt=4 on reg_q=0x8001 → reg_sl high 4 consecutive cycles, reg_il following the MSB each cycle; done at T+5; result=0x0018.
3. INC amt=15 on 0xFFFA → reg_inc high 15 cycles; result=0x0009 (wrap). Then DEC amt=9 → result=0x0000.
4. SHL amt=0 on 0x1234 → no control pin ever high; done at T+1; result=0x1234. ROR amt=1 on 0x0001 → result=0x8000.
5. cmd_valid held high throughout a 3-cycle SHR, with a second command presented → second command not accepted until IDLE. It is then accepted at the end of cycle T+5, with no cycle lost and no duplicate execution.
6. rst_n pulsed low in the 2nd EXEC cycle of INC amt=8 → controls drop at once, no done pulse, cmd_ready=1. After release, CLR completes with result=0x0000.
